// File: rtl/cpu_run_controller.sv
// Run sequencer for single_cycle_cpu: streams a program image into instruction
// memory with the CPU held in reset, then runs it until halt or cycle budget.
module cpu_run_controller #(
   parameter int          IMEM_WORDS = 64,
   parameter int          MAX_CYCLES = 1000,
   parameter logic [31:0] HALT_INSTR = 32'h0000_0063
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic        imem_we,
   output logic [31:0] imem_waddr,
   output logic [31:0] imem_wdata,
   output logic        cpu_rst,
   input  logic [63:0] cpu_debug,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic        load_trunc,
   output logic [31:0] cycle_count,
   output logic [31:0] halt_pc
);

   localparam int CNT_W = $clog2(IMEM_WORDS) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CPU_RESET,
      S_RUN,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_word_cnt;
   logic [31:0]        r_cycle_count;
   logic [31:0]        r_halt_pc;
   logic               r_cpu_rst;
   logic               r_busy;
   logic               r_done;
   logic               r_timeout;
   logic               r_load_trunc;
   logic               w_load_ready;
   logic               w_accept;
   logic               w_last_slot;
   logic               w_halt;
   logic               w_budget_end;

   assign w_load_ready = (r_state == S_LOAD);
   assign w_accept     = w_load_ready && load_valid;
   assign w_last_slot  = (r_word_cnt == CNT_W'(IMEM_WORDS - 1));
   assign w_halt       = (cpu_debug[31:0] == HALT_INSTR);
   assign w_budget_end = (r_cycle_count == 32'(MAX_CYCLES - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (start) w_next = S_LOAD;
         S_LOAD:      if (w_accept && (load_last || w_last_slot)) w_next = S_CPU_RESET;
         S_CPU_RESET: w_next = S_RUN;
         S_RUN:       if (w_halt || w_budget_end) w_next = S_DONE;
         S_DONE:      if (start) w_next = S_LOAD;
         default:     w_next = S_IDLE;
      endcase
   end

   // State register; status outputs are registered from the next state so they
   // line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cpu_rst <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cpu_rst <= (w_next == S_IDLE) || (w_next == S_LOAD) || (w_next == S_CPU_RESET);
         r_busy    <= (w_next == S_LOAD) || (w_next == S_CPU_RESET) || (w_next == S_RUN);
         r_done    <= (w_next == S_DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_word_cnt    <= '0;
         r_cycle_count <= '0;
         r_halt_pc     <= '0;
         r_timeout     <= 1'b0;
         r_load_trunc  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_word_cnt    <= '0;
                  r_cycle_count <= '0;
                  r_halt_pc     <= '0;
                  r_timeout     <= 1'b0;
                  r_load_trunc  <= 1'b0;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_word_cnt <= r_word_cnt + 1'b1;
                  if (!load_last && w_last_slot) r_load_trunc <= 1'b1;
               end
            end
            S_RUN: begin
               // Halt wins over budget: the halt cycle itself is not counted.
               if (w_halt) begin
                  r_halt_pc <= cpu_debug[63:32];
               end else begin
                  r_cycle_count <= r_cycle_count + 32'd1;
                  if (w_budget_end) r_timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign load_ready  = w_load_ready;
   assign imem_we     = w_accept;
   assign imem_waddr  = {{(30 - CNT_W){1'b0}}, r_word_cnt, 2'b00};
   assign imem_wdata  = load_data;
   assign cpu_rst     = r_cpu_rst;
   assign busy        = r_busy;
   assign done        = r_done;
   assign timeout     = r_timeout;
   assign load_trunc  = r_load_trunc;
   assign cycle_count = r_cycle_count;
   assign halt_pc     = r_halt_pc;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized bench for cpu_run_controller with a small behavioural CPU that
// fetches from the memory the controller loads.
module tb_cpu_run_controller;

   localparam int          IMEM_WORDS = 8;
   localparam int          MAX_CYCLES = 16;
   localparam logic [31:0] HALT       = 32'h0000_0063;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_last;
   logic        load_ready;
   logic        imem_we;
   logic [31:0] imem_waddr;
   logic [31:0] imem_wdata;
   logic        cpu_rst;
   logic [63:0] cpu_debug;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        load_trunc;
   logic [31:0] cycle_count;
   logic [31:0] halt_pc;

   always #5 clk = ~clk;

   cpu_run_controller #(
      .IMEM_WORDS (IMEM_WORDS),
      .MAX_CYCLES (MAX_CYCLES),
      .HALT_INSTR (HALT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .imem_we     (imem_we),
      .imem_waddr  (imem_waddr),
      .imem_wdata  (imem_wdata),
      .cpu_rst     (cpu_rst),
      .cpu_debug   (cpu_debug),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout),
      .load_trunc  (load_trunc),
      .cycle_count (cycle_count),
      .halt_pc     (halt_pc)
   );

   // Behavioural CPU: PC held at 0 in reset, otherwise advances by 4 unless
   // the fetched word is the halt self-loop.
   logic [31:0] mem [64];
   logic        mem_clr;
   logic [31:0] pc;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) mem[i] <= NOP;
      end else if (imem_we) begin
         mem[imem_waddr[7:2]] <= imem_wdata;
      end
      if (cpu_rst) pc <= 32'd0;
      else if (mem[pc[7:2]] != HALT) pc <= pc + 32'd4;
   end

   assign cpu_debug = {pc, mem[pc[7:2]]};

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          crst_cycles = 0;

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr_q.push_back(imem_waddr);
         wr_data_q.push_back(imem_wdata);
      end
      if (busy && cpu_rst && !load_ready) crst_cycles++;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_addi();
      logic [11:0] imm;
      logic [4:0]  rd;
      imm = 12'($urandom);
      rd  = 5'($urandom);
      return {imm, 5'd0, 3'b000, rd, 7'b0010011};
   endfunction

   task automatic load_image(input logic [31:0] img[$], input bit use_last, input int max_gap);
      start = 1'b1;
      step();
      start = 1'b0;
      check_eq("start_busy", busy, 1);
      check_eq("start_ready", load_ready, 1);
      check_eq("start_cpu_rst", cpu_rst, 1);
      check_eq("start_done_clr", done, 0);
      check_eq("start_timeout_clr", timeout, 0);
      check_eq("start_trunc_clr", load_trunc, 0);
      check_eq("start_count_clr", cycle_count, 0);
      check_eq("start_halt_pc_clr", halt_pc, 0);
      for (int i = 0; i < img.size(); i++) begin
         repeat ($urandom_range(0, max_gap)) begin
            load_valid = 1'b0;
            start      = busy && ($urandom_range(0, 3) == 0);
            step();
         end
         load_valid = 1'b1;
         load_data  = img[i];
         load_last  = use_last && (i == img.size() - 1);
         start      = busy && ($urandom_range(0, 3) == 0);
         step();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      start      = 1'b0;
   endtask

   task automatic run_test(input string name, input logic [31:0] img[$], input bit use_last,
                           input int max_gap);
      int acc;
      bit exp_trunc;
      int hk;
      bit exp_to;
      int wbase;
      int cbase;
      int t;
      // Reference: words accepted until last or memory full; halt found among them.
      acc       = 0;
      exp_trunc = 1'b1;
      for (int i = 0; i < img.size(); i++) begin
         acc = i + 1;
         if (use_last && i == img.size() - 1) begin
            exp_trunc = 1'b0;
            break;
         end
         if (acc == IMEM_WORDS) break;
      end
      hk = -1;
      for (int i = 0; i < acc; i++) begin
         if (img[i] == HALT) begin
            hk = i;
            break;
         end
      end
      exp_to = !(hk >= 0 && hk < MAX_CYCLES);

      mem_clr = 1'b1;
      step();
      mem_clr = 1'b0;
      wbase = wr_addr_q.size();
      cbase = crst_cycles;
      load_image(img, use_last, max_gap);

      t = 0;
      while (!done && t < 300) begin
         start = busy && ($urandom_range(0, 7) == 0);
         step();
         t++;
      end
      start = 1'b0;
      check_eq({name, "_done_in_time"}, 32'(t < 300), 1);
      check_eq({name, "_done"}, done, 1);
      check_eq({name, "_busy"}, busy, 0);
      check_eq({name, "_cpu_rst"}, cpu_rst, 0);
      check_eq({name, "_load_ready"}, load_ready, 0);
      check_eq({name, "_timeout"}, timeout, exp_to);
      check_eq({name, "_trunc"}, load_trunc, exp_trunc);
      check_eq({name, "_cycles"}, cycle_count, exp_to ? MAX_CYCLES : hk);
      check_eq({name, "_halt_pc"}, halt_pc, exp_to ? 0 : 4 * hk);
      check_eq({name, "_crst_cycles"}, crst_cycles - cbase, 1);
      check_eq({name, "_nwrites"}, wr_addr_q.size() - wbase, acc);
      for (int i = 0; i < acc && wbase + i < wr_addr_q.size(); i++) begin
         check_eq({name, "_waddr"}, wr_addr_q[wbase + i], 4 * i);
         check_eq({name, "_wdata"}, wr_data_q[wbase + i], img[i]);
      end
      repeat (3) step();
      check_eq({name, "_done_hold"}, done, 1);
      check_eq({name, "_cycles_hold"}, cycle_count, exp_to ? MAX_CYCLES : hk);
   endtask

   initial begin
      logic [31:0] img[$];
      bit          ul;
      int          n;
      int          t;
      rst        = 1'b1;
      start      = 1'b0;
      load_valid = 1'b0;
      load_data  = 32'd0;
      load_last  = 1'b0;
      mem_clr    = 1'b1;
      repeat (3) step();
      rst     = 1'b0;
      mem_clr = 1'b0;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_cpu_rst", cpu_rst, 1);
      check_eq("rst_ready", load_ready, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_timeout", timeout, 0);
      check_eq("rst_trunc", load_trunc, 0);
      check_eq("rst_count", cycle_count, 0);
      check_eq("rst_halt_pc", halt_pc, 0);

      img = '{32'h0050_0093, 32'h0010_8113, HALT};
      run_test("basic", img, 1'b1, 0);
      img = '{32'h0050_0093, 32'h0010_8113};
      run_test("budget", img, 1'b1, 0);
      img = '{32'h0050_0093, 32'h0010_8113, HALT};
      run_test("gaps", img, 1'b1, 2);
      img = '{};
      for (int i = 0; i < IMEM_WORDS + 2; i++) img.push_back(rand_addi());
      run_test("trunc", img, 1'b0, 1);

      for (int k = 0; k < 12; k++) begin
         n  = $urandom_range(1, IMEM_WORDS + 3);
         ul = (n < IMEM_WORDS) ? 1'b1 : 1'(($urandom_range(0, 1)));
         img = '{};
         for (int i = 0; i < n; i++) img.push_back(rand_addi());
         if ($urandom_range(0, 2) != 0) img[$urandom_range(0, n - 1)] = HALT;
         run_test("rand", img, ul, 2);
      end

      // Reset while running: must land in IDLE with counters cleared.
      mem_clr = 1'b1;
      step();
      mem_clr = 1'b0;
      img = '{NOP, NOP, NOP, NOP, NOP, NOP};
      load_image(img, 1'b1, 0);
      t = 0;
      while (!(busy && !cpu_rst && cycle_count == 32'd3) && t < 100) begin
         step();
         t++;
      end
      check_eq("midrun_reached", 32'(t < 100), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("midrun_rst_busy", busy, 0);
      check_eq("midrun_rst_cpu_rst", cpu_rst, 1);
      check_eq("midrun_rst_count", cycle_count, 0);
      check_eq("midrun_rst_done", done, 0);
      check_eq("midrun_rst_ready", load_ready, 0);
      step();
      check_eq("idle_stays", busy, 0);

      img = '{32'h0050_0093, HALT};
      run_test("after_rst", img, 1'b1, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
